ram_clock_supervisor: RTL and testbench
=======================================

# ram_clock_supervisor

Sequencer for the 133 MHz RAM clock PLL, running in the 50 MHz `refclk` domain beside the PLL wrapper. It drives the PLL reset, synchronizes and qualifies the PLL `locked` flag, and releases the RAM-side reset only after lock has been stable for a programmed time. On lock loss, lock timeout or software request it re-sequences the PLL and counts retries.

## Interface
- `RST_CYCLES`, default 16: cycles `pll_rst` is held high per attempt (≥2).
- `LOCK_TIMEOUT`, default 65536: maximum cycles spent in WAIT_LOCK before a retry (≥2).
- `STABLE_CYCLES`, default 1024: consecutive synchronized-lock cycles required before RUN (≥1).
- `MAX_RETRIES`, default 4: failures tolerated before FAULT; used only with the macro.
- `refclk` input 1: 50 MHz reference; the only clock.
- `rst_n` input 1: reset, synchronous and active-low.
- `locked` input 1: PLL lock flag, asynchronous to `refclk`.
- `relock_req` input 1: single-cycle request to re-sequence the PLL.
- `pll_rst` output 1: PLL reset, active-high.
- `ram_rst_n` output 1: RAM-domain reset, active-low, registered in the `refclk` domain.
- `clk_ready` output 1: high only in RUN.
- `lost_lock` output 1: one-cycle pulse when lock drops in RUN.
- `retry_count` output 8: saturating failure count.
- `fault` output 1: sticky retry-limit fault; constant 0 without the macro.
- `state` output 3: encoded state for debug. PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.

## Operation
- `locked` passes through a 2-flop synchronizer to form `lock_s`. Only `lock_s` is used.
- One shared cycle counter, wide enough for the largest parameter, clears on every state change.
- All outputs are registered and derived from the next state, so they change on the same edge as `state`.
- Reset values: `state`=PLL_RST, `pll_rst`=1, `ram_rst_n`=0, `clk_ready`=0, `lost_lock`=0, `retry_count`=0, `fault`=0, counter=0, synchronizer flops=0.
- PLL_RST: `pll_rst`=1. After RST_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0.
  - If `lock_s`=1, go to STABLE.
  - If the counter reaches LOCK_TIMEOUT−1 with `lock_s`=0, record a failure and go to PLL_RST.
- STABLE:
  - If `lock_s`=0, record a failure and go to PLL_RST.
  - After STABLE_CYCLES consecutive cycles with `lock_s`=1, go to RUN.
- RUN: `ram_rst_n`=1 and `clk_ready`=1. If `lock_s`=0, record a failure, pulse `lost_lock` and go to PLL_RST. `ram_rst_n` returns to 0 on that same edge.
- Failure recording: `retry_count` increments and saturates at 255.
- `relock_req` in any state except FAULT forces PLL_RST on the next edge and does not record a failure. When it coincides with a failure condition, `relock_req` wins and no increment occurs.
- `ram_rst_n`=0 and `clk_ready`=0 in every state other than RUN.

## Timing
- PLL reset pulse: `pll_rst` is high for exactly RST_CYCLES cycles per attempt, including the first attempt after reset.
- Lock acquisition: if `locked` is first sampled high at edge k and stays high, `state`=STABLE after edge k+2. `clk_ready` and `ram_rst_n` rise after edge k+2+STABLE_CYCLES.
- Lock loss: `lock_s` falls two edges after `locked` falls. `clk_ready` falls and `lost_lock` pulses on the following edge, 3 edges total.
- Timeout: WAIT_LOCK lasts exactly LOCK_TIMEOUT cycles when no lock arrives.
- Mid-operation reset: `rst_n` low at any edge restores all reset values on that edge, regardless of state.

## Configuration
- `RAM_CLOCK_SUP_RETRY_LIMIT_EN` defined: the failure that makes `retry_count` reach MAX_RETRIES enters FAULT instead of PLL_RST.
  - FAULT holds `pll_rst`=1, `ram_rst_n`=0, `clk_ready`=0 and `fault`=1.
  - FAULT ignores `locked` and `relock_req` and exits only via `rst_n`.
- Macro not defined: retries are unlimited, the FAULT state is absent, and `fault` is tied to 0.

## Test plan
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.

- Clean start: release `rst_n`, raise `locked` 10 cycles later.
  - `pll_rst` is high for exactly 4 cycles.
  - `clk_ready` rises 10 edges after the first edge that samples `locked`=1.
  - `retry_count`=0.
- Timeout: keep `locked`=0.
  - WAIT_LOCK lasts 32 cycles, then `pll_rst` pulses for 4 cycles.
  - `retry_count` goes 0→1→2 across successive attempts.
  - With the macro: `fault`=1 and `state`=4 after the second timeout.
- Lock loss in RUN: drop `locked` for 1 cycle.
  - `lost_lock` pulses once; `clk_ready` and `ram_rst_n` fall 3 edges later.
  - `retry_count` increments, then the PLL re-sequences to RUN.
- Glitch in STABLE: drop `locked` at STABLE cycle 5.
  - Returns to PLL_RST with `retry_count`+1; `clk_ready` never asserts.
- `relock_req` in RUN coinciding with a lock drop: next state is PLL_RST and `retry_count` is unchanged.
- Reset mid-WAIT_LOCK: assert `rst_n`=0 for one cycle.
  - All outputs return to reset values; the counter restarts the 4-cycle PLL reset.

Source files
------------

// File: rtl/ram_clock_supervisor.sv
// RAM clock PLL sequencer in the refclk domain: PLL reset, lock qualification, RAM reset release.
// Optional retry limit / FAULT state enabled by defining RAM_CLOCK_SUP_RETRY_LIMIT_EN.
module ram_clock_supervisor #(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 65536,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned MAX_RETRIES   = 4
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       locked,
   input  logic       relock_req,
   output logic       pll_rst,
   output logic       ram_rst_n,
   output logic       clk_ready,
   output logic       lost_lock,
   output logic [7:0] retry_count,
   output logic       fault,
   output logic [2:0] state
);

   localparam int unsigned CNT_MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned CNT_MAX    = (CNT_MAX_AB > STABLE_CYCLES) ? CNT_MAX_AB : STABLE_CYCLES;
   localparam int unsigned CW         = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3
`ifdef RAM_CLOCK_SUP_RETRY_LIMIT_EN
      , S_FAULT   = 3'd4
`endif
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_sync1;
   logic            r_lock_s;
   logic [CW-1:0]   r_cnt;
   logic            r_pll_rst;
   logic            r_ram_rst_n;
   logic            r_clk_ready;
   logic            r_lost_lock;
   logic [7:0]      r_retry;
   logic            w_fail;
   logic            w_restart;
   logic [7:0]      w_retry_inc;

   assign w_retry_inc = (r_retry == 8'hFF) ? 8'hFF : r_retry + 8'd1;
   assign w_restart   = relock_req && (r_state == S_PLL_RST);

   always_ff @(posedge refclk) begin
      if (!rst_n) r_state <= S_PLL_RST;
      else        r_state <= w_next;
   end

   // relock_req is checked first in every live state so it overrides a coincident failure
   always_comb begin
      w_next = r_state;
      w_fail = 1'b0;
      case (r_state)
         S_PLL_RST: begin
            if (!relock_req && r_cnt == CW'(RST_CYCLES - 1)) w_next = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (relock_req)                                w_next = S_PLL_RST;
            else if (r_lock_s)                             w_next = S_STABLE;
            else if (r_cnt == CW'(LOCK_TIMEOUT - 1))       w_fail = 1'b1;
         end
         S_STABLE: begin
            if (relock_req)                                w_next = S_PLL_RST;
            else if (!r_lock_s)                            w_fail = 1'b1;
            else if (r_cnt == CW'(STABLE_CYCLES - 1))      w_next = S_RUN;
         end
         S_RUN: begin
            if (relock_req)                                w_next = S_PLL_RST;
            else if (!r_lock_s)                            w_fail = 1'b1;
         end
`ifdef RAM_CLOCK_SUP_RETRY_LIMIT_EN
         S_FAULT:  w_next = S_FAULT;
`endif
         default:  w_next = S_PLL_RST;
      endcase
      if (w_fail) begin
`ifdef RAM_CLOCK_SUP_RETRY_LIMIT_EN
         w_next = (32'(w_retry_inc) >= MAX_RETRIES) ? S_FAULT : S_PLL_RST;
`else
         w_next = S_PLL_RST;
`endif
      end
   end

   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         r_sync1     <= 1'b0;
         r_lock_s    <= 1'b0;
         r_cnt       <= '0;
         r_pll_rst   <= 1'b1;
         r_ram_rst_n <= 1'b0;
         r_clk_ready <= 1'b0;
         r_lost_lock <= 1'b0;
         r_retry     <= '0;
      end else begin
         r_sync1     <= locked;
         r_lock_s    <= r_sync1;
         r_cnt       <= (w_next != r_state || w_restart) ? '0 : r_cnt + 1'b1;
`ifdef RAM_CLOCK_SUP_RETRY_LIMIT_EN
         r_pll_rst   <= (w_next == S_PLL_RST) || (w_next == S_FAULT);
`else
         r_pll_rst   <= (w_next == S_PLL_RST);
`endif
         r_ram_rst_n <= (w_next == S_RUN);
         r_clk_ready <= (w_next == S_RUN);
         r_lost_lock <= w_fail && (r_state == S_RUN);
         if (w_fail) r_retry <= w_retry_inc;
      end
   end

`ifdef RAM_CLOCK_SUP_RETRY_LIMIT_EN
   logic r_fault;

   always_ff @(posedge refclk) begin
      if (!rst_n) r_fault <= 1'b0;
      else        r_fault <= (w_next == S_FAULT);
   end

   assign fault = r_fault;
`else
   // MAX_RETRIES only matters when the retry limit is compiled in
   if (MAX_RETRIES == 0) begin : g_retry_limit_unused
   end

   assign fault = 1'b0;
`endif

   assign pll_rst     = r_pll_rst;
   assign ram_rst_n   = r_ram_rst_n;
   assign clk_ready   = r_clk_ready;
   assign lost_lock   = r_lost_lock;
   assign retry_count = r_retry;
   assign state       = r_state;

endmodule

// File: tb/tb_ram_clock_supervisor.sv
// Randomised + scenario bench for ram_clock_supervisor against a cycle-level reference model.
module tb_ram_clock_supervisor;

   localparam int unsigned RST  = 4;
   localparam int unsigned TO   = 32;
   localparam int unsigned STB  = 8;
   localparam int unsigned MAXR = 2;

   logic       refclk = 1'b0;
   logic       rst_n_i = 1'b0;
   logic       locked_i = 1'b0;
   logic       relock_i = 1'b0;
   logic       pll_rst;
   logic       ram_rst_n;
   logic       clk_ready;
   logic       lost_lock;
   logic [7:0] retry_count;
   logic       fault;
   logic [2:0] state;

   int n_cmp = 0;
   int n_mis = 0;
   int edge_no = 0;

   // reference model: phase 0=PLL_RST 1=WAIT_LOCK 2=STABLE 3=RUN 4=FAULT
   int m_phase, m_time, m_retry;
   bit m_hist [2];
   bit m_pll, m_ready, m_lost, m_fault;

   always #10 refclk = ~refclk;

   ram_clock_supervisor #(
      .RST_CYCLES   (RST),
      .LOCK_TIMEOUT (TO),
      .STABLE_CYCLES(STB),
      .MAX_RETRIES  (MAXR)
   ) dut (
      .refclk     (refclk),
      .rst_n      (rst_n_i),
      .locked     (locked_i),
      .relock_req (relock_i),
      .pll_rst    (pll_rst),
      .ram_rst_n  (ram_rst_n),
      .clk_ready  (clk_ready),
      .lost_lock  (lost_lock),
      .retry_count(retry_count),
      .fault      (fault),
      .state      (state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s @edge %0d: got %0d, expected %0d", tag, edge_no, obs, exp);
      end
   endtask

   task automatic model_edge();
      int  nxt;
      bit  fail;
      bit  restart;
      bit  ls;
      if (!rst_n_i) begin
         m_phase = 0; m_time = 0; m_retry = 0;
         m_hist[0] = 0; m_hist[1] = 0;
         m_pll = 1; m_ready = 0; m_lost = 0; m_fault = 0;
         return;
      end
      ls = m_hist[1];
      nxt = m_phase; fail = 0; restart = 0;
      if (m_phase != 4 && relock_i) begin
         nxt = 0; restart = 1;
      end else begin
         case (m_phase)
            0: if (m_time == RST - 1) nxt = 1;
            1: if (ls) nxt = 2; else if (m_time == TO - 1) fail = 1;
            2: if (!ls) fail = 1; else if (m_time == STB - 1) nxt = 3;
            3: if (!ls) fail = 1;
            default: ;
         endcase
      end
      m_lost = fail && (m_phase == 3);
      if (fail) begin
         if (m_retry < 255) m_retry++;
         nxt = 0;
`ifdef RAM_CLOCK_SUP_RETRY_LIMIT_EN
         if (m_retry >= MAXR) nxt = 4;
`endif
      end
      m_time  = (nxt != m_phase || restart) ? 0 : m_time + 1;
      m_phase = nxt;
      m_hist[1] = m_hist[0];
      m_hist[0] = locked_i;
      m_pll   = (nxt == 0) || (nxt == 4);
      m_ready = (nxt == 3);
      m_fault = (nxt == 4);
   endtask

   task automatic step();
      @(posedge refclk);
      edge_no++;
      model_edge();
      @(negedge refclk);
      check("state",       32'(state),       32'(m_phase));
      check("pll_rst",     32'(pll_rst),     32'(m_pll));
      check("ram_rst_n",   32'(ram_rst_n),   32'(m_ready));
      check("clk_ready",   32'(clk_ready),   32'(m_ready));
      check("lost_lock",   32'(lost_lock),   32'(m_lost));
      check("retry_count", 32'(retry_count), 32'(m_retry));
      check("fault",       32'(fault),       32'(m_fault));
   endtask

   task automatic do_reset();
      rst_n_i = 1'b0; relock_i = 1'b0;
      step(); step();
      rst_n_i = 1'b1;
   endtask

   initial begin
      int hi;
      int k;
      int r;
      int j;
      int saved;

      // clean start
      locked_i = 1'b0;
      rst_n_i = 1'b0; step(); step();
      hi = pll_rst ? 1 : 0;
      rst_n_i = 1'b1;
      for (int i = 0; i < 10; i++) begin step(); hi += pll_rst ? 1 : 0; end
      check("pll_rst_len", 32'(hi), 32'(RST));
      locked_i = 1'b1;
      step(); k = edge_no; r = k + 99;
      for (int i = 0; i < 20 && r == k + 99; i++) begin step(); if (clk_ready) r = edge_no; end
      check("ready_latency", 32'(r - k), 32'(2 + STB));
      check("start_retry", 32'(retry_count), 32'd0);

      // one-cycle lock drop in RUN
      locked_i = 1'b0; step(); j = edge_no; locked_i = 1'b1;
      r = j + 99;
      for (int i = 0; i < 6 && r == j + 99; i++) begin step(); if (lost_lock) r = edge_no; end
      check("lost_latency", 32'(r - j), 32'd2);
      for (int i = 0; i < 30; i++) step();
`ifndef RAM_CLOCK_SUP_RETRY_LIMIT_EN
      check("relock_run", 32'(clk_ready), 32'd1);
`endif

      // glitch during STABLE
      relock_i = 1'b1; step(); relock_i = 1'b0;
      for (int i = 0; i < 40 && !(m_phase == 2 && m_time == 4); i++) step();
      saved = m_retry;
      locked_i = 1'b0; step(); locked_i = 1'b1; step(); step();
`ifndef RAM_CLOCK_SUP_RETRY_LIMIT_EN
      check("glitch_retry", 32'(retry_count), 32'(saved + 1));
      check("glitch_state", 32'(state), 32'd0);
`endif
      for (int i = 0; i < 40; i++) step();

      // relock_req coinciding with lock loss in RUN
      do_reset();
      for (int i = 0; i < 40 && m_phase != 3; i++) step();
      check("reach_run", 32'(state), 32'd3);
      locked_i = 1'b0; step(); step();
      saved = m_retry;
      relock_i = 1'b1; step(); relock_i = 1'b0; locked_i = 1'b1;
      check("relock_state", 32'(state), 32'd0);
      check("relock_retry", 32'(retry_count), 32'(saved));
      for (int i = 0; i < 20; i++) step();

      // timeouts
      do_reset();
      locked_i = 1'b0;
      for (int i = 0; i < 2 * (TO + RST) + 10; i++) step();
`ifdef RAM_CLOCK_SUP_RETRY_LIMIT_EN
      check("timeout_fault", 32'(fault), 32'd1);
      check("timeout_state", 32'(state), 32'd4);
`else
      check("timeout_retry", 32'(retry_count), 32'd2);
`endif

      // reset in the middle of WAIT_LOCK
      do_reset();
      for (int i = 0; i < 40 && !(m_phase == 1 && m_time == 10); i++) step();
      rst_n_i = 1'b0; step();
      hi = pll_rst ? 1 : 0;
      check("midrst_state", 32'(state), 32'd0);
      rst_n_i = 1'b1;
      for (int i = 0; i < 8; i++) begin step(); hi += pll_rst ? 1 : 0; end
      check("midrst_pll_len", 32'(hi), 32'(RST));

      // retry counter saturation
      do_reset();
      for (int i = 0; i < 260 * (TO + RST); i++) step();
`ifdef RAM_CLOCK_SUP_RETRY_LIMIT_EN
      check("sat_retry", 32'(retry_count), 32'(MAXR));
`else
      check("sat_retry", 32'(retry_count), 32'd255);
`endif

      // random traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (locked_i) begin
            if ($urandom_range(59) == 0) locked_i = 1'b0;
         end else begin
            if ($urandom_range(14) == 0) locked_i = 1'b1;
         end
         relock_i = ($urandom_range(149) == 0);
         rst_n_i  = ($urandom_range(599) != 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
